// File: rtl/dmem_access_unit.sv
// Load/store unit between the core data port and a synchronous-read data RAM.
// Handles RV32I access sizes, sub-word read-modify-write stores and access faults.
module dmem_access_unit #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    input  logic              req_write_i,
    input  logic [31:0]       req_addr_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [31:0]       req_wdata_i,
    output logic [31:0]       rdata_o,
    output logic              done_o,
    output logic              fault_o,
    output logic              stall_o,
    output logic [ADDR_W-1:0] ram_address_o,
    output logic              ram_read_o,
    output logic              ram_write_o,
    output logic [31:0]       ram_datain_o,
    input  logic [31:0]       ram_dataout_i
);

    localparam int unsigned BA_W = ADDR_W + 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_WAIT,
        RMW_READ,
        RMW_WRITE,
        ACK
    } state_e;

    state_e            state_q, state_d;
    logic [BA_W-1:0]   addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [31:0]       merge_q, merge_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              fault_q, fault_d;

    logic              req_fault_c;
    logic              ram_read_c, ram_write_c;
    logic [31:0]       ram_datain_c;
    logic [ADDR_W-1:0] ram_address_c;
    logic [31:0]       load_val_c, merged_c;

    // Request fault detection: illegal funct3, misalignment, address beyond RAM
    always_comb begin
        logic f3_bad;
        logic misalign;
        logic oor;
        if (req_write_i) begin
            f3_bad = req_funct3_i[2] | (req_funct3_i[1:0] == 2'b11);
        end else begin
            f3_bad = (req_funct3_i == 3'b011) | (req_funct3_i[2:1] == 2'b11);
        end
        misalign = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                   ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
        oor = (req_addr_i >> BA_W) != 32'd0;
        req_fault_c = f3_bad | misalign | oor;
    end

    // Lane extraction with sign/zero extension, and sub-word merge for RMW
    always_comb begin
        logic [31:0] shifted;
        logic [15:0] half;
        logic [4:0]  shamt;
        logic [31:0] mask;
        logic [31:0] ins;
        shifted = ram_dataout_i >> {addr_q[1:0], 3'b000};
        half    = addr_q[1] ? ram_dataout_i[31:16] : ram_dataout_i[15:0];
        case (funct3_q)
            3'b000:  load_val_c = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val_c = {{16{half[15]}}, half};
            3'b100:  load_val_c = {24'd0, shifted[7:0]};
            3'b101:  load_val_c = {16'd0, half};
            default: load_val_c = ram_dataout_i;
        endcase
        if (funct3_q[1:0] == 2'b00) begin
            shamt = {addr_q[1:0], 3'b000};
            mask  = 32'h0000_00ff << shamt;
            ins   = 32'(wdata_q[7:0]) << shamt;
        end else begin
            shamt = {addr_q[1], 4'b0000};
            mask  = 32'h0000_ffff << shamt;
            ins   = 32'(wdata_q) << shamt;
        end
        merged_c = (ram_dataout_i & ~mask) | (ins & mask);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        funct3_d      = funct3_q;
        wdata_d       = wdata_q;
        merge_d       = merge_q;
        rdata_d       = rdata_q;
        fault_d       = fault_q;
        ram_read_c    = 1'b0;
        ram_write_c   = 1'b0;
        ram_datain_c  = 32'd0;
        ram_address_c = addr_q[BA_W-1:2];
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d        = req_addr_i[BA_W-1:0];
                    funct3_d      = req_funct3_i;
                    wdata_d       = req_wdata_i[15:0];
                    ram_address_c = req_addr_i[BA_W-1:2];
                    if (req_fault_c) begin
                        fault_d = 1'b1;
                        state_d = ACK;
                    end else if (req_write_i && (req_funct3_i[1:0] == 2'b10)) begin
                        ram_write_c  = 1'b1;
                        ram_datain_c = req_wdata_i;
                        state_d      = ACK;
                    end else if (req_write_i) begin
                        ram_read_c = 1'b1;
                        state_d    = RMW_READ;
                    end else begin
                        ram_read_c = 1'b1;
                        state_d    = LOAD_WAIT;
                    end
                end
            end
            LOAD_WAIT: begin
                rdata_d = load_val_c;
                state_d = ACK;
            end
            RMW_READ: begin
                merge_d = merged_c;
                state_d = RMW_WRITE;
            end
            RMW_WRITE: begin
                ram_write_c  = 1'b1;
                ram_datain_c = merge_q;
                state_d      = ACK;
            end
            ACK: begin
                fault_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are gated by reset so an in-flight write is dropped immediately
    assign ram_read_o    = ram_read_c & ~rst_i;
    assign ram_write_o   = ram_write_c & ~rst_i;
    assign ram_datain_o  = ram_datain_c;
    assign ram_address_o = ram_address_c;
    assign rdata_o       = rdata_q;
    assign fault_o       = fault_q;
    assign done_o        = (state_q == ACK);
    assign stall_o       = req_valid_i & ~done_o;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed self-checking bench for dmem_access_unit with a behavioural synchronous RAM.
module tb_dmem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic [31:0] rdata;
    logic        done;
    logic        fault;
    logic        stall;
    logic [9:0]  ram_address;
    logic        ram_read;
    logic        ram_write;
    logic [31:0] ram_datain;
    logic [31:0] ram_dataout;

    dmem_access_unit #(.ADDR_W(10)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_write_i   (req_write),
        .req_addr_i    (req_addr),
        .req_funct3_i  (req_funct3),
        .req_wdata_i   (req_wdata),
        .rdata_o       (rdata),
        .done_o        (done),
        .fault_o       (fault),
        .stall_o       (stall),
        .ram_address_o (ram_address),
        .ram_read_o    (ram_read),
        .ram_write_o   (ram_write),
        .ram_datain_o  (ram_datain),
        .ram_dataout_i (ram_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    logic [31:0] rd_q;
    int          cyc = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          rd_cyc = 0;
    int          wr_cyc = 0;
    int          both_cnt = 0;
    logic [31:0] wr_last = 32'd0;

    // RAM model plus strobe bookkeeping
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_read && ram_write) both_cnt <= both_cnt + 1;
        if (ram_read) begin
            rd_q   <= mem[ram_address];
            rd_cnt <= rd_cnt + 1;
            rd_cyc <= cyc;
        end
        if (ram_write) begin
            mem[ram_address] <= ram_datain;
            wr_cnt  <= wr_cnt + 1;
            wr_cyc  <= cyc;
            wr_last <= ram_datain;
        end
    end
    assign ram_dataout = rd_q;

    int   total = 0;
    int   bad = 0;
    int   lat;
    int   stalls;
    int   rd0;
    int   wr0;
    logic flt;
    logic flt_after;
    logic got_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One access; chg_at >= 1 rewrites req_wdata on that cycle after acceptance
    task automatic access(input logic w, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] wd, input int chg_at, input logic [31:0] chg_val);
        @(negedge clk);
        req_write  = w;
        req_addr   = a;
        req_funct3 = f3;
        req_wdata  = wd;
        req_valid  = 1'b1;
        lat = 0;
        stalls = 0;
        got_done = 1'b0;
        flt = 1'bx;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        while (!got_done && lat < 10) begin
            if (lat == chg_at) req_wdata = chg_val;
            #1;
            if (stall) stalls++;
            if (done) begin
                got_done = 1'b1;
                flt = fault;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
        flt_after = fault;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr = 32'h10;
        req_funct3 = 3'b010;
        req_wdata = 32'h1;
        #1;
        chk("rst_wr_gated", 32'(ram_write), 32'd0);
        chk("rst_rd_gated", 32'(ram_read), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        access(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, -1, 32'd0);
        chk("sw_lat", 32'(lat), 32'd1);
        chk("sw_fault", 32'(flt), 32'd0);
        chk("sw_writes", 32'(wr_cnt - wr0), 32'd1);
        chk("sw_mem", mem[4], 32'hDEADBEEF);

        access(1'b0, 32'h10, 3'b010, 32'd0, -1, 32'd0);
        chk("lw_lat", 32'(lat), 32'd2);
        chk("lw_fault", 32'(flt), 32'd0);
        chk("lw_rdata", rdata, 32'hDEADBEEF);

        access(1'b0, 32'h13, 3'b000, 32'd0, -1, 32'd0);
        chk("lb_rdata", rdata, 32'hFFFFFFDE);
        access(1'b0, 32'h13, 3'b100, 32'd0, -1, 32'd0);
        chk("lbu_rdata", rdata, 32'h000000DE);
        access(1'b0, 32'h10, 3'b001, 32'd0, -1, 32'd0);
        chk("lh_rdata", rdata, 32'hFFFFBEEF);
        access(1'b0, 32'h12, 3'b101, 32'd0, -1, 32'd0);
        chk("lhu_rdata", rdata, 32'h0000DEAD);

        access(1'b1, 32'h11, 3'b000, 32'h00000055, -1, 32'd0);
        chk("sb_lat", 32'(lat), 32'd3);
        chk("sb_stalls", 32'(stalls), 32'd3);
        chk("sb_reads", 32'(rd_cnt - rd0), 32'd1);
        chk("sb_writes", 32'(wr_cnt - wr0), 32'd1);
        chk("sb_order", 32'(wr_cyc > rd_cyc), 32'd1);
        chk("sb_wdata", wr_last, 32'hDEAD55EF);
        chk("sb_mem", mem[4], 32'hDEAD55EF);

        access(1'b1, 32'h12, 3'b001, 32'h00001234, 1, 32'hFFFFFFFF);
        chk("sh_lat", 32'(lat), 32'd3);
        chk("sh_mem", mem[4], 32'h123455EF);

        access(1'b0, 32'h12, 3'b010, 32'd0, -1, 32'd0);
        chk("f_lw_mis_lat", 32'(lat), 32'd1);
        chk("f_lw_mis_fault", 32'(flt), 32'd1);
        chk("f_lw_mis_strobes", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);
        chk("f_lw_mis_rdata", rdata, 32'h0000DEAD);
        chk("f_lw_mis_clear", 32'(flt_after), 32'd0);

        access(1'b0, 32'h11, 3'b001, 32'd0, -1, 32'd0);
        chk("f_lh_mis_lat", 32'(lat), 32'd1);
        chk("f_lh_mis_fault", 32'(flt), 32'd1);
        chk("f_lh_mis_strobes", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);
        chk("f_lh_mis_rdata", rdata, 32'h0000DEAD);

        access(1'b0, 32'h10, 3'b011, 32'd0, -1, 32'd0);
        chk("f_f3_lat", 32'(lat), 32'd1);
        chk("f_f3_fault", 32'(flt), 32'd1);
        chk("f_f3_strobes", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);
        chk("f_f3_rdata", rdata, 32'h0000DEAD);

        access(1'b1, 32'h1000, 3'b010, 32'h11111111, -1, 32'd0);
        chk("f_oor_lat", 32'(lat), 32'd1);
        chk("f_oor_fault", 32'(flt), 32'd1);
        chk("f_oor_strobes", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);
        chk("f_oor_mem0", mem[0] === 32'h11111111 ? 32'd1 : 32'd0, 32'd0);
        chk("f_oor_clear", 32'(flt_after), 32'd0);

        access(1'b1, 32'h14, 3'b010, 32'hCAFEF00D, -1, 32'd0);
        chk("sw2_mem", mem[5], 32'hCAFEF00D);

        // Reset during the RMW write cycle of an SB
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr = 32'h14;
        req_funct3 = 3'b000;
        req_wdata = 32'h77;
        wr0 = wr_cnt;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("abort_wr_before", 32'(ram_write), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_wr_drop", 32'(ram_write), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_fault", 32'(fault), 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("abort_writes", 32'(wr_cnt - wr0), 32'd0);
        chk("abort_mem", mem[5], 32'hCAFEF00D);

        access(1'b0, 32'h14, 3'b010, 32'd0, -1, 32'd0);
        chk("post_abort_lat", 32'(lat), 32'd2);
        chk("post_abort_rdata", rdata, 32'hCAFEF00D);

        // Back-to-back loads with REQ_VALID held through DONE
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr = 32'h10;
        req_funct3 = 3'b010;
        #1;
        chk("b2b_c0_done", 32'(done), 32'd0);
        @(negedge clk);
        #1;
        chk("b2b_c1_done", 32'(done), 32'd0);
        @(negedge clk);
        #1;
        chk("b2b_c2_done", 32'(done), 32'd1);
        chk("b2b_first_rdata", rdata, 32'h123455EF);
        req_addr = 32'h14;
        @(negedge clk);
        #1;
        chk("b2b_c3_done", 32'(done), 32'd0);
        chk("b2b_c3_accept", 32'(ram_read), 32'd1);
        chk("b2b_c3_stall", 32'(stall), 32'd1);
        @(negedge clk);
        #1;
        chk("b2b_c4_done", 32'(done), 32'd0);
        @(negedge clk);
        #1;
        chk("b2b_c5_done", 32'(done), 32'd1);
        chk("b2b_second_rdata", rdata, 32'hCAFEF00D);
        req_valid = 1'b0;
        @(negedge clk);

        chk("never_both_strobes", 32'(both_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
